fp32_accumulator: RTL and testbench
===================================

# fp32_accumulator

Sequential FP32 accumulator that sits directly downstream of `fp_8_to_32_multiplier`. It sums a stream of FP32 products into one FP32 result per dot-product group. Each input is consumed over a multi-cycle align/add/normalize FSM with round-to-nearest-even. The finished sum is presented on a valid/ready output port, together with sticky exception flags.

## Interface
- No parameters; the format is fixed at IEEE-754 binary32.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: synchronous, active-low reset.
- `in_valid` in 1: `in_data` and `in_last` are valid.
- `in_ready` out 1: accumulator can accept an input.
- `in_data` in 32: FP32 product to add.
- `in_last` in 1: final element of the current group.
- `out_valid` out 1: group sum available.
- `out_ready` in 1: consumer accepts the sum.
- `out_data` out 32: FP32 group sum.
- `out_flags` out 3: sticky flags for the group. `[0]` = invalid, `[1]` = overflow, `[2]` = inexact.

## Operation
- **FSM states:** IDLE, ALIGN, ADD, NORM, OUT.
- **IDLE:** `in_ready=1`. A handshake (`in_valid&in_ready` at a rising edge) latches `in_data` and `in_last`, then the FSM goes to ALIGN.
- **ALIGN:**
  - Unpack the accumulator `acc` and the operand into 24-bit significands (hidden bit included), extended with guard/round/sticky bits to 27 bits.
  - Swap the operands so the larger magnitude is first.
  - Right-shift the smaller operand by min(exponent difference, 27). All shifted-out bits are ORed into sticky.
- **ADD:** 28-bit add, or subtract when the signs differ. The result sign is the sign of the larger operand.
- **NORM:**
  - Normalize with a leading-zero count; a carry-out shifts right by 1.
  - Round to nearest, ties to even. A mantissa carry from rounding increments the exponent.
  - Write the result to `acc` and OR the new flags into the sticky flags.
  - If the latched `last` is set, go to OUT; otherwise return to IDLE.
- **OUT:** `out_valid=1`, with `out_data=acc` and `out_flags=flags` held stable. On `out_valid&out_ready`, clear `acc` to +0 and the flags to 0, then go to IDLE.
- **Special values:**
  - Denormals are flushed to zero: an input with exp=0 is treated as a signed zero. A result below 2^-126 becomes a signed zero and sets inexact.
  - Exact zero result is +0, except -0 + -0 = -0.
  - Any NaN input, or +Inf + -Inf, gives 0x7FC00000 and sets invalid.
  - Inf plus a finite value gives that Inf.
  - A finite overflow gives ±Inf and sets overflow and inexact.
- Once `acc` is NaN it stays NaN until the group ends.

## Timing
- **Reset:** `rstn=0` at an edge forces IDLE, `acc=+0` and flags=0 regardless of state, including mid-FSM or in OUT. The pending group is discarded.
- **Output values during reset:** `in_ready=0`, `out_valid=0`, `out_data=0`, `out_flags=0`.
- **Input throughput:** an input handshake at edge N gives ALIGN at N+1, ADD at N+2 and NORM at N+3.
  - `in_ready` is high again at N+4 if the input was not last, i.e. one input per 4 cycles.
  - `in_ready` is low in all states except IDLE; `in_valid` held during that time is simply not accepted.
- **Output timing:**
  - With `in_last` set, `out_valid` rises at N+4.
  - The output handshake at edge M returns the FSM to IDLE with `in_ready=1` at M+1.
  - `in_ready` and `out_valid` are never high in the same cycle.
- **Backpressure:** while `out_ready=0` in OUT, `out_data`, `out_flags` and `out_valid` hold indefinitely and no input is accepted.
- **Single-element group:** a group with `in_last` on the first element returns that element unchanged (+0 + x = x). -0 is the exception: it returns +0.

## Configuration
- Macro: `FP32_ACC_SATURATE_EN`.
- **Defined:** finite overflow saturates to ±0x7F7FFFFF (max finite) instead of ±Inf; the overflow and inexact flags are still set. Inf and NaN inputs are unaffected.
- **Undefined:** overflow gives ±Inf (0x7F800000 / 0xFF800000).

## Test plan
- **Basic sum with handshake timing:**
  - Stimulus: 0x3F800000 (1.0), then 0x40000000 (2.0) with last.
  - Required: `out_data`=0x40400000 and flags=000, with `out_valid` 4 cycles after the second handshake.
  - Also check that `in_ready` toggles exactly per the Timing section.
- **Cancellation and rounding ties:**
  - 0x3F800000 + 0xBF800000 → 0x00000000.
  - 0x3F800000 + 0x33800000 → 0x3F800000 (tie, stays even), inexact=1.
  - 0x3F800001 + 0x33800000 → 0x3F800002 (tie rounds up to even).
- **Overflow:**
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, flags=110.
  - With `FP32_ACC_SATURATE_EN` defined → 0x7F7FFFFF, flags=110.
- **Invalid:**
  - 0x7F800000 + 0xFF800000 → 0x7FC00000, flags[0]=1.
  - A NaN input followed by 0x3F800000 (last) → 0x7FC00000.
- **Backpressure and group restart:**
  - Hold `out_ready=0` for 5 cycles: `out_data` must be stable and `in_ready=0` throughout.
  - After the output handshake, a new group with 0x40400000 (last) → 0x40400000, proving the accumulator cleared.
- **Reset mid-operation:**
  - Assert `rstn=0` for one edge while in ADD.
  - Required: IDLE next cycle, `in_ready=1` after release. A subsequent group 0x3F800000 (last) → 0x3F800000 with flags=000.

Source files
------------

// File: rtl/fp32_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : fp32_accumulator
// Description : Sequential IEEE-754 binary32 accumulator. Each accepted input
//               is added into the running group sum over an
//               IDLE -> ALIGN -> ADD -> NORM sequence with round-to-nearest-
//               even. The sum of a group (closed by in_last) is presented in
//               OUT with sticky exception flags until the consumer accepts it.
//               Denormal inputs and results are flushed to signed zero.
// Ports       : clk        - clock, rising edge
//               rstn       - synchronous active-low reset
//               in_valid   - in_data / in_last valid
//               in_ready   - accumulator can take an input (IDLE only)
//               in_data    - FP32 operand
//               in_last    - operand closes the current group
//               out_valid  - group sum available (OUT only)
//               out_ready  - consumer accepts the sum
//               out_data   - FP32 group sum
//               out_flags  - sticky flags {inexact, overflow, invalid}
// Options     : FP32_ACC_SATURATE_EN - when defined, finite overflow returns
//               +/-max-finite instead of +/-Inf (flags unchanged).
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_accumulator (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_flags
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    localparam logic [31:0] C_QNAN = 32'h7FC0_0000;
`ifdef FP32_ACC_SATURATE_EN
    localparam logic [30:0] C_OVF_MAG = 31'h7F7F_FFFF;
`else
    localparam logic [30:0] C_OVF_MAG = 31'h7F80_0000;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [31:0] r_acc;
    logic [2:0]  r_flags;
    logic [31:0] r_op;
    logic        r_last;
    logic        r_special;     // result fixed by Inf/NaN rules, bypasses datapath
    logic        r_spec_nan;
    logic [31:0] r_spec_val;
    logic [26:0] r_big;         // larger significand with G/R/S bits
    logic [26:0] r_small;       // aligned smaller significand with G/R/S bits
    logic [7:0]  r_exp;         // exponent of the larger operand
    logic        r_sign;
    logic        r_sub;
    logic        r_neg_zero;    // both operands are -0: exact zero keeps sign
    logic [27:0] r_sum;

    // ------------------------------------------------------------------
    // ALIGN: classify, order by magnitude, align the smaller operand
    // ------------------------------------------------------------------
    logic [7:0]  w_a_exp, w_b_exp;
    logic        w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic [30:0] w_a_mag, w_b_mag;
    logic        w_swap;
    logic [23:0] w_a_sig, w_b_sig, w_big_sig, w_small_sig;
    logic [7:0]  w_big_exp, w_small_exp, w_diff;
    logic [4:0]  w_shamt;
    logic [26:0] w_small_ext, w_shifted, w_mask, w_aligned;
    logic        w_lost;
    logic        w_nan;

    assign w_a_exp  = r_acc[30:23];
    assign w_b_exp  = r_op[30:23];
    assign w_a_zero = (w_a_exp == 8'h00);
    assign w_b_zero = (w_b_exp == 8'h00);
    assign w_a_inf  = (w_a_exp == 8'hFF) && (r_acc[22:0] == 23'd0);
    assign w_b_inf  = (w_b_exp == 8'hFF) && (r_op[22:0] == 23'd0);
    assign w_a_nan  = (w_a_exp == 8'hFF) && (r_acc[22:0] != 23'd0);
    assign w_b_nan  = (w_b_exp == 8'hFF) && (r_op[22:0] != 23'd0);

    // Flushed magnitudes: exponent 0 means zero regardless of the fraction.
    assign w_a_mag  = w_a_zero ? 31'd0 : r_acc[30:0];
    assign w_b_mag  = w_b_zero ? 31'd0 : r_op[30:0];
    assign w_a_sig  = w_a_zero ? 24'd0 : {1'b1, r_acc[22:0]};
    assign w_b_sig  = w_b_zero ? 24'd0 : {1'b1, r_op[22:0]};
    assign w_swap   = (w_b_mag > w_a_mag);

    assign w_big_sig   = w_swap ? w_b_sig : w_a_sig;
    assign w_small_sig = w_swap ? w_a_sig : w_b_sig;
    assign w_big_exp   = w_swap ? w_b_exp : w_a_exp;
    assign w_small_exp = w_swap ? w_a_exp : w_b_exp;
    assign w_diff      = w_big_exp - w_small_exp;
    assign w_shamt     = (w_diff > 8'd27) ? 5'd27 : w_diff[4:0];

    // Everything shifted past bit 0 collapses into the sticky bit.
    assign w_small_ext = {w_small_sig, 3'b000};
    assign w_shifted   = w_small_ext >> w_shamt;
    assign w_mask      = ~(27'h7FF_FFFF << w_shamt);
    assign w_lost      = |(w_small_ext & w_mask);
    assign w_aligned   = {w_shifted[26:1], w_shifted[0] | w_lost};

    assign w_nan = w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r_acc[31] != r_op[31]));

    // ------------------------------------------------------------------
    // NORM: leading-zero count, normalize, round to nearest even
    // ------------------------------------------------------------------
    logic [4:0]         w_lz;
    logic [26:0]        w_norm;
    logic signed [9:0]  w_exp_pre, w_exp_fin;
    logic               w_guard, w_rs, w_rnd_up, w_inexact;
    logic [24:0]        w_mant_rnd;
    logic [22:0]        w_frac;
    logic [31:0]        w_res;
    logic [2:0]         w_res_flags;

    // Highest set bit of the no-carry sum wins (ascending scan).
    always_comb begin
        w_lz = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (r_sum[i]) begin
                w_lz = 5'(26 - i);
            end
        end
    end

    assign w_norm    = r_sum[27] ? {r_sum[27:2], r_sum[1] | r_sum[0]}
                                 : (r_sum[26:0] << w_lz);
    assign w_exp_pre = r_sum[27] ? ($signed({2'b00, r_exp}) + 10'sd1)
                                 : ($signed({2'b00, r_exp}) - $signed({5'd0, w_lz}));

    assign w_guard    = w_norm[2];
    assign w_rs       = w_norm[1] | w_norm[0];
    assign w_rnd_up   = w_guard & (w_rs | w_norm[3]);
    assign w_inexact  = w_guard | w_rs;
    assign w_mant_rnd = {1'b0, w_norm[26:3]} + {24'd0, w_rnd_up};
    // Rounding carry leaves 1.000..0, so the fraction is the upper bits.
    assign w_exp_fin  = w_exp_pre + (w_mant_rnd[24] ? 10'sd1 : 10'sd0);
    assign w_frac     = w_mant_rnd[24] ? w_mant_rnd[23:1] : w_mant_rnd[22:0];

    always_comb begin
        w_res       = r_spec_val;
        w_res_flags = {2'b00, r_spec_nan};
        if (!r_special) begin
            if (r_sum == 28'd0) begin
                w_res       = {r_neg_zero, 31'd0};
                w_res_flags = 3'b000;
            end else if (w_exp_fin > 10'sd254) begin
                w_res       = {r_sign, C_OVF_MAG};
                w_res_flags = 3'b110;
            end else if (w_exp_fin < 10'sd1) begin
                w_res       = {r_sign, 31'd0};
                w_res_flags = 3'b100;
            end else begin
                w_res       = {r_sign, w_exp_fin[7:0], w_frac};
                w_res_flags = {w_inexact, 2'b00};
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_acc      <= 32'd0;
            r_flags    <= 3'b000;
            r_op       <= 32'd0;
            r_last     <= 1'b0;
            r_special  <= 1'b0;
            r_spec_nan <= 1'b0;
            r_spec_val <= 32'd0;
            r_big      <= 27'd0;
            r_small    <= 27'd0;
            r_exp      <= 8'd0;
            r_sign     <= 1'b0;
            r_sub      <= 1'b0;
            r_neg_zero <= 1'b0;
            r_sum      <= 28'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_op    <= in_data;
                        r_last  <= in_last;
                        r_state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    r_special  <= w_nan || w_a_inf || w_b_inf;
                    r_spec_nan <= w_nan;
                    r_spec_val <= w_nan ? C_QNAN : (w_a_inf ? r_acc : r_op);
                    r_big      <= {w_big_sig, 3'b000};
                    r_small    <= w_aligned;
                    r_exp      <= w_big_exp;
                    r_sign     <= w_swap ? r_op[31] : r_acc[31];
                    r_sub      <= r_acc[31] ^ r_op[31];
                    r_neg_zero <= w_a_zero && w_b_zero && r_acc[31] && r_op[31];
                    r_state    <= S_ADD;
                end
                S_ADD: begin
                    // Larger magnitude is first, so subtraction never borrows out.
                    r_sum   <= r_sub ? ({1'b0, r_big} - {1'b0, r_small})
                                     : ({1'b0, r_big} + {1'b0, r_small});
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    r_acc   <= w_res;
                    r_flags <= r_flags | w_res_flags;
                    r_state <= r_last ? S_OUT : S_IDLE;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_acc   <= 32'd0;
                        r_flags <= 3'b000;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = rstn && (r_state == S_IDLE);
    assign out_valid = (r_state == S_OUT);
    assign out_data  = r_acc;
    assign out_flags = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_fp32_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp32_accumulator
// Description : Self-checking bench for fp32_accumulator. Directed groups
//               cover the basic sum, cancellation, rounding ties, overflow,
//               invalid, backpressure and mid-operation reset; randomized
//               groups are checked against an exact-integer reference model.
//               Honours FP32_ACC_SATURATE_EN for the overflow result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp32_accumulator;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_flags;

`ifdef FP32_ACC_SATURATE_EN
    localparam logic [30:0] C_OVF_MAG = 31'h7F7F_FFFF;
`else
    localparam logic [30:0] C_OVF_MAG = 31'h7F80_0000;
`endif

    fp32_accumulator dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_acc;
    logic [2:0]  m_flags;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact sum as an integer in units of 2^-149, then rounded
    // to nearest-even with an unbounded exponent and range-checked.
    function automatic void model_add(input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic [2:0] f);
        logic         a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn, half, rest;
        logic [299:0] va, vb, mag, sig, one, rem_mask;
        int           p, biased;
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        r = 32'd0;
        f = 3'b000;
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
            r = 32'h7FC0_0000;
            f = 3'b001;
        end else if (a_inf) begin
            r = a;
        end else if (b_inf) begin
            r = b;
        end else if (a_zero && b_zero) begin
            r = {a[31] & b[31], 31'd0};
        end else begin
            va = a_zero ? 300'd0 : (300'({1'b1, a[22:0]}) << (int'(a[30:23]) - 1));
            vb = b_zero ? 300'd0 : (300'({1'b1, b[22:0]}) << (int'(b[30:23]) - 1));
            if (a[31] == b[31]) begin
                mag = va + vb;
                sgn = a[31];
            end else if (va >= vb) begin
                mag = va - vb;
                sgn = a[31];
            end else begin
                mag = vb - va;
                sgn = b[31];
            end
            if (mag == 300'd0) begin
                r = 32'd0;
            end else begin
                p = 0;
                for (int i = 0; i < 300; i++) if (mag[i]) p = i;
                half = 1'b0;
                rest = 1'b0;
                if (p <= 23) begin
                    sig = mag << (23 - p);
                end else begin
                    sig      = mag >> (p - 23);
                    half     = mag[p - 24];
                    one      = 300'd1;
                    rem_mask = (one << (p - 24)) - one;
                    rest     = |(mag & rem_mask);
                end
                biased = p - 22;
                if (half && (rest || sig[0])) sig = sig + 300'd1;
                if (sig[24]) begin
                    sig = sig >> 1;
                    biased++;
                end
                if (biased > 254) begin
                    r = {sgn, C_OVF_MAG};
                    f = 3'b110;
                end else if (biased < 1) begin
                    r = {sgn, 31'd0};
                    f = 3'b100;
                end else begin
                    r = {sgn, 8'(biased), sig[22:0]};
                    f = {half | rest, 2'b00};
                end
            end
        end
    endfunction

    // Offer one element, then check the ready/valid cadence after acceptance.
    task automatic send(input logic [31:0] d, input logic l);
        int          waited;
        logic [31:0] r;
        logic [2:0]  f;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            check_value("in_ready_wait", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            tick();                 // handshake edge
            in_valid = 1'b0;
            model_add(m_acc, d, r, f);
            m_acc   = r;
            m_flags = m_flags | f;
            for (int k = 0; k < 3; k++) begin
                check_value("busy_in_ready", 32'(in_ready), 32'd0);
                check_value("busy_out_valid", 32'(out_valid), 32'd0);
                tick();
            end
            check_value("post_in_ready", 32'(in_ready), 32'(!l));
            check_value("post_out_valid", 32'(out_valid), 32'(l));
        end
    endtask

    // Collect a group sum, optionally stalling the consumer first.
    task automatic recv(input int hold);
        int waited;
        waited = 0;
        while (!out_valid && waited < 50) begin
            tick();
            waited++;
        end
        check_value("out_valid", 32'(out_valid), 32'd1);
        if (out_valid) begin
            check_value("out_data", out_data, m_acc);
            check_value("out_flags", 32'(out_flags), 32'(m_flags));
            for (int i = 0; i < hold; i++) begin
                tick();
                check_value("hold_valid", 32'(out_valid), 32'd1);
                check_value("hold_data", out_data, m_acc);
                check_value("hold_flags", 32'(out_flags), 32'(m_flags));
                check_value("hold_in_ready", 32'(in_ready), 32'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check_value("ret_in_ready", 32'(in_ready), 32'd1);
            check_value("ret_out_valid", 32'(out_valid), 32'd0);
        end
        m_acc   = 32'd0;
        m_flags = 3'b000;
    endtask

    function automatic logic [31:0] rand_val();
        int          kind;
        logic        s;
        logic [22:0] m;
        logic [7:0]  e;
        kind = int'($urandom_range(0, 19));
        s    = 1'($urandom_range(0, 1));
        m    = 23'($urandom);
        case (kind)
            0:       return {s, 31'd0};
            1:       return {s, 8'h00, m};
            2:       return {s, 8'hFF, 23'd0};
            3:       return {s, 8'hFF, m | 23'd1};
            4:       e = 8'($urandom_range(250, 254));
            5:       e = 8'($urandom_range(1, 4));
            default: e = 8'($urandom_range(118, 136));
        endcase
        return {s, e, m};
    endfunction

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        m_acc     = 32'd0;
        m_flags   = 3'b000;
        repeat (3) tick();
        check_value("rst_in_ready", 32'(in_ready), 32'd0);
        check_value("rst_out_valid", 32'(out_valid), 32'd0);
        check_value("rst_out_data", out_data, 32'd0);
        check_value("rst_out_flags", 32'(out_flags), 32'd0);
        rstn = 1'b1;
        #1;
        check_value("rel_in_ready", 32'(in_ready), 32'd1);

        // Basic sum
        send(32'h3F80_0000, 1'b0);
        send(32'h4000_0000, 1'b1);
        recv(0);
        // Cancellation and ties
        send(32'h3F80_0000, 1'b0);
        send(32'hBF80_0000, 1'b1);
        recv(0);
        send(32'h3F80_0000, 1'b0);
        send(32'h3380_0000, 1'b1);
        recv(0);
        send(32'h3F80_0001, 1'b0);
        send(32'h3380_0000, 1'b1);
        recv(0);
        // Overflow
        send(32'h7F7F_FFFF, 1'b0);
        send(32'h7F7F_FFFF, 1'b1);
        recv(0);
        // Invalid
        send(32'h7F80_0000, 1'b0);
        send(32'hFF80_0000, 1'b1);
        recv(0);
        send(32'h7FA0_0000, 1'b0);
        send(32'h3F80_0000, 1'b1);
        recv(0);
        // Single -0 element
        send(32'h8000_0000, 1'b1);
        recv(0);
        // Backpressure with a competing input offered, then group restart
        send(32'h4000_0000, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        in_last  = 1'b1;
        recv(5);
        send(32'h4040_0000, 1'b1);
        recv(0);

        // Reset while in ADD
        in_valid = 1'b1;
        in_data  = 32'h3F80_0000;
        in_last  = 1'b0;
        tick();                     // handshake edge
        in_valid = 1'b0;
        tick();                     // now in ADD
        rstn = 1'b0;
        tick();
        check_value("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check_value("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_value("mid_rst_out_data", out_data, 32'd0);
        check_value("mid_rst_out_flags", 32'(out_flags), 32'd0);
        rstn = 1'b1;
        #1;
        check_value("mid_rel_in_ready", 32'(in_ready), 32'd1);
        m_acc   = 32'd0;
        m_flags = 3'b000;
        send(32'h3F80_0000, 1'b1);
        recv(0);

        // Randomized groups
        for (int g = 0; g < 40; g++) begin
            int n;
            n = int'($urandom_range(1, 5));
            for (int i = 0; i < n; i++) begin
                send(rand_val(), 1'(i == n - 1));
            end
            recv(int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
